// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and PC constants for the fetch sequencer
package pc_sequencer_pkg;

    localparam int PC_W_DEFAULT     = 5;
    localparam int RESET_PC_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_offset_adder.sv
// rtl/pc_offset_adder.sv - branch target adder, base plus raw low offset bits, modulo 2^PC_W
// Ports:
//   base   in  PC_W  address the offset is relative to
//   offset in  16    instruction offset field; only [PC_W-1:0] participate
//   target out PC_W  base + offset[PC_W-1:0], wrapping
module pc_offset_adder
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] base,
    input  logic [15:0]     offset,
    output logic [PC_W-1:0] target
);

    // Upper offset bits are deliberately ignored; negative offsets work via wrap.
    logic unused_offset_bits;
    assign unused_offset_bits = ^offset[15:PC_W];

    assign target = base + offset[PC_W-1:0];

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and instruction fetch sequencer
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   stall                            hold pc, no new fetch
//   br_req, br_taken, br_base,
//   br_const                         resolved branch and its target operands
//   jmp_req, jmp_addr                absolute jump
//   halt_req, resume                 enter / leave HALT
//   pc, pc_plus_4                    fetch address and its sequential successor
//   fetch_en, flush, halted          fetch valid, kill fetch/decode slot, halt status
//   redirect_cnt                     saturating count of taken branches plus jumps
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int PC_INC       = 1,
    parameter int RESET_PC     = RESET_PC_DEFAULT,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_req,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_base,
    input  logic [15:0]      br_const,
    input  logic             jmp_req,
    input  logic [PC_W-1:0]  jmp_addr,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus_4,
    output logic             fetch_en,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [1:0]      FLUSH_LOAD = 2'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_RESET   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(PC_INC);

    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] br_target;
    logic [1:0]      flush_cnt, flush_cnt_nxt;
    logic            redirect;

    pc_offset_adder #(.PC_W(PC_W)) u_br_adder (
        .base   (br_base),
        .offset (br_const),
        .target (br_target)
    );

    assign pc_plus_4 = pc + PC_STEP;
    assign halted    = (state == ST_HALT);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        flush_cnt_nxt = flush_cnt;
        fetch_en      = 1'b0;
        redirect      = 1'b0;
        case (state)
            ST_START: state_nxt = ST_RUN;
            ST_RUN, ST_FLUSH: begin
                // The redirected PC is fetched during bubbles; only RUN honours stall.
                fetch_en = (state == ST_FLUSH) ? 1'b1 : ~stall;
                if (state == ST_FLUSH) begin
                    if (flush_cnt <= 2'd1) begin
                        state_nxt = ST_RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 2'd1;
                    end
                end
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (jmp_req) begin
                    pc_nxt   = jmp_addr;
                    redirect = 1'b1;
                end else if (br_req && br_taken) begin
                    pc_nxt   = br_target;
                    redirect = 1'b1;
                end else if (!stall) begin
                    pc_nxt = pc_plus_4;
                end
                // A redirect inside FLUSH restarts the bubble window.
                if (redirect) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_START;
            pc           <= PC_RESET;
            flush_cnt    <= 2'd0;
            flush        <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            flush_cnt <= flush_cnt_nxt;
            flush     <= (state_nxt == ST_FLUSH);
            if (redirect && (redirect_cnt != {CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 5-bit program counter and sequences instruction fetch each cycle: sequential increment, branch redirect, jump redirect, stall, flush bubbles, halt/resume.
- Drives the branch-target adder (pc_offset_adder) and selects the next PC from it.
- Sits between the decode/branch-resolve logic and instruction memory; pc drives the imem address directly.

Parameters:
- PC_W, 5, PC width in bits; all PC arithmetic is modulo 2^PC_W.
- PC_INC, 1, sequential increment (word addressed, so no x4 scaling).
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 1, bubble cycles after any redirect (1..3).
- CNT_W, 8, width of redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no new fetch.
- br_req  in  1  branch resolved this cycle.
- br_taken  in  1  branch condition true; qualified by br_req.
- br_base  in  PC_W  pc_plus_4 of the branch instruction.
- br_const  in  16  sign/offset field from the instruction; only bits [PC_W-1:0] are used.
- jmp_req  in  1  absolute jump this cycle.
- jmp_addr  in  PC_W  jump target.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc  out  PC_W  current fetch address.
- pc_plus_4  out  PC_W  pc + PC_INC, combinational.
- fetch_en  out  1  imem read valid this cycle.
- flush  out  1  kill the instruction in the fetch/decode register.
- halted  out  1  in HALT state.
- redirect_cnt  out  CNT_W  count of taken branches plus jumps.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high: it acts only on the rising edge of clk while rst=1.
- Reset values: pc=RESET_PC, state=START, flush=0, halted=0, redirect_cnt=0, fetch_en=0.
- State machine:
  - START: one cycle; fetch_en=0 -> RUN.
  - RUN: fetch_en = ~stall.
  - FLUSH: fetch_en=1 at the redirected PC; flush=1 for FLUSH_CYCLES cycles, counted by an internal down-counter; then -> RUN.
  - HALT: fetch_en=0, halted=1, pc frozen; resume=1 -> RUN on the next cycle.
- Next-PC priority, evaluated in RUN and FLUSH:
  1. halt_req: pc holds -> HALT.
  2. jmp_req: pc <= jmp_addr.
  3. br_req & br_taken: pc <= br_base + br_const[PC_W-1:0].
  4. stall: pc holds.
  5. Otherwise: pc <= pc + PC_INC.
- Redirect (cases 2 and 3):
  - Overrides stall, since the resolved branch must not be lost.
  - Enters FLUSH with the counter loaded to FLUSH_CYCLES.
  - redirect_cnt increments by 1 and saturates at all-ones.
- A new redirect while in FLUSH is accepted: PC updates and the flush counter reloads.
- br_req with br_taken=0: no effect on pc beyond the normal increment/stall rule; not counted.
- All arithmetic wraps modulo 2^PC_W, e.g. 31+1=0 and 30+5=3. No overflow flag.
- The offset is taken raw from the low PC_W bits. Negative offsets work through the modulo wrap.
- halt_req and jmp_req in the same cycle: halt wins; the jump is dropped.
- resume is ignored outside HALT. halt_req is ignored inside HALT.
- flush is a registered output. pc_plus_4 is combinational from pc.
- rst asserted mid-FLUSH or mid-HALT: next cycle is START with all reset values.
- Latency: a redirect presented in cycle N appears on pc in cycle N+1.

Decomposition:
- Shared package: state encoding (START, RUN, FLUSH, HALT; 2-bit), PC_W, and RESET_PC constants.
- Branch target: instantiate the existing pc_offset_adder (br_base, br_const -> target).
- Sequential incrementer: kept inline.

Test Plan:
- Reset then run, no stalls: pc sequence 0 (START, fetch_en=0), 0, 1, 2, 3; flush=0 throughout.
- Taken branch at pc=4, br_base=5, br_const=16'h0003: pc=8 next cycle; flush=1 for 1 cycle; redirect_cnt=1. Same with br_taken=0: pc=5, count unchanged.
- Wrap cases:
  - pc=31, no events: next pc=0.
  - br_base=2, br_const=16'hFFFE: target 0.
  - br_base=30, br_const=5: target 3.
- Simultaneous events:
  - jmp_req (addr 20), br taken (target 9) and stall in one cycle: pc=20.
  - halt_req plus jmp_req: pc holds, halted=1, next pc still unchanged.
- HALT then resume: pc=7 frozen for 5 cycles, fetch_en=0; resume -> pc 7, 8 with fetch_en=1. resume while in RUN has no effect.
- rst asserted during FLUSH (FLUSH_CYCLES=3, second bubble cycle): next cycle pc=0, flush=0, redirect_cnt=0, state START.
